// File: rtl/lsu_stage.sv
// lsu_stage: multi-cycle load/store unit between execute and writeback.
// Takes one memory op at a time, drives a word-addressed data memory with
// byte strobes, waits for read-valid (with timeout) and returns extended
// load data or store completion as a one-cycle response pulse.
// Build option: define MISALIGN_TRAP_EN to turn misaligned halfword/word
// accesses into error responses; otherwise they are aligned down silently.

module lsu_stage #(
    parameter int AWIDTH         = 32,
    parameter int DWIDTH         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                memren_i,
    input  logic                memwren_i,
    input  logic [2:0]          funct3_i,
    input  logic [AWIDTH-1:0]   addr_i,
    input  logic [DWIDTH-1:0]   store_data_i,
    input  logic [4:0]          rd_i,
    output logic                resp_valid_o,
    output logic                resp_wb_o,
    output logic [DWIDTH-1:0]   resp_data_o,
    output logic [4:0]          resp_rd_o,
    output logic                err_o,
    output logic                busy_o,
    output logic [AWIDTH-1:0]   dmem_addr_o,
    output logic [DWIDTH-1:0]   dmem_wdata_o,
    output logic [DWIDTH/8-1:0] dmem_wstrb_o,
    output logic                dmem_read_en_o,
    output logic                dmem_write_en_o,
    input  logic                dmem_rvalid_i,
    input  logic [DWIDTH-1:0]   dmem_rdata_i
);

    localparam int NLANES = DWIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_hit;

    // Registered request
    logic              is_load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [NLANES-1:0] wstrb_q;
    logic              err_q;
    logic [DWIDTH-1:0] data_q;

    // Request decode
    logic              accept;
    logic              req_bad;
    logic              f3_legal;
    logic [1:0]        off_in;
    logic [1:0]        off_eff;
    logic [NLANES-1:0] wstrb_in;
    logic [DWIDTH-1:0] wdata_in;
`ifdef MISALIGN_TRAP_EN
    logic              misaligned;
`endif

    // Load data alignment/extension
    logic [DWIDTH-1:0] shifted;
    logic [DWIDTH-1:0] load_ext;

    // Decode the incoming request: legality, lane offset, strobes and store data
    always_comb begin
        off_in = addr_i[1:0];
        accept = (state == IDLE) && req_valid_i && (memren_i || memwren_i);

        if (memren_i)
            f3_legal = !(funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111);
        else
            f3_legal = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);

        // Halfwords align down to an even lane, words to lane 0
        case (funct3_i[1:0])
            2'b01:   off_eff = {off_in[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = off_in;
        endcase

        case (funct3_i[1:0])
            2'b00:   wstrb_in = NLANES'(1) << off_eff;
            2'b01:   wstrb_in = off_eff[1] ? NLANES'(4'b1100) : NLANES'(4'b0011);
            2'b10:   wstrb_in = '1;
            default: wstrb_in = '0;
        endcase

        case (funct3_i[1:0])
            2'b00:   wdata_in = {NLANES{store_data_i[7:0]}};
            2'b01:   wdata_in = {(NLANES/2){store_data_i[15:0]}};
            default: wdata_in = store_data_i;
        endcase

`ifdef MISALIGN_TRAP_EN
        misaligned = (funct3_i[1:0] == 2'b01 && off_in[0]) ||
                     (funct3_i[1:0] == 2'b10 && off_in != 2'b00);
        req_bad    = (memren_i && memwren_i) || !f3_legal || misaligned;
`else
        req_bad    = (memren_i && memwren_i) || !f3_legal;
`endif
    end

    // Shift the returned word down to the addressed lane and extend it
    always_comb begin
        shifted = dmem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Next-state logic; rvalid takes priority over the timeout
    always_comb begin
        state_next  = state;
        timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE: if (accept) state_next = req_bad ? RESP : REQ;
            REQ:  state_next = is_load_q ? WAIT : RESP;
            WAIT: if (dmem_rvalid_i || timeout_hit) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, timeout counter and request/response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            rd_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (accept) begin
                        is_load_q <= memren_i && !memwren_i;
                        funct3_q  <= funct3_i;
                        off_q     <= off_eff;
                        rd_q      <= rd_i;
                        addr_q    <= {addr_i[AWIDTH-1:2], 2'b00};
                        wdata_q   <= wdata_in;
                        wstrb_q   <= wstrb_in;
                        err_q     <= req_bad;
                        data_q    <= '0;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (dmem_rvalid_i)
                        data_q <= load_ext;
                    else if (timeout_hit)
                        err_q <= 1'b1;
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

    // Output decode; response fields are zero outside the response pulse
    always_comb begin
        req_ready_o     = (state == IDLE) && !rst;
        busy_o          = (state != IDLE);
        resp_valid_o    = (state == RESP) && !rst;
        resp_data_o     = resp_valid_o ? data_q : '0;
        resp_rd_o       = resp_valid_o ? rd_q : '0;
        err_o           = resp_valid_o && err_q;
        resp_wb_o       = resp_valid_o && is_load_q && !err_q;
        dmem_read_en_o  = (state == REQ) && is_load_q;
        dmem_write_en_o = (state == REQ) && !is_load_q;
        dmem_addr_o     = (state == REQ) ? addr_q : '0;
        dmem_wdata_o    = (state == REQ && !is_load_q) ? wdata_q : '0;
        dmem_wstrb_o    = (state == REQ && !is_load_q) ? wstrb_q : '0;
    end

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: randomized self-checking bench for lsu_stage.
// The bench plays the data memory and predicts each response from the
// load/store rules (sizes, lane offsets, extension, latency, timeout).

module tb_lsu_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        memren_i;
    logic        memwren_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        resp_valid_o;
    logic        resp_wb_o;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        err_o;
    logic        busy_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_read_en_o;
    logic        dmem_write_en_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    lsu_stage #(
        .AWIDTH(32),
        .DWIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .memren_i(memren_i),
        .memwren_i(memwren_i),
        .funct3_i(funct3_i),
        .addr_i(addr_i),
        .store_data_i(store_data_i),
        .rd_i(rd_i),
        .resp_valid_o(resp_valid_o),
        .resp_wb_o(resp_wb_o),
        .resp_data_o(resp_data_o),
        .resp_rd_o(resp_rd_o),
        .err_o(err_o),
        .busy_o(busy_o),
        .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o),
        .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_read_en_o(dmem_read_en_o),
        .dmem_write_en_o(dmem_write_en_o),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One transaction: k = cycles after the REQ cycle at which rvalid is given (0 = never)
    task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rd, input logic [31:0] word, input int k);
        int          size, off, eff, exp_c, resp_c, stray, leak;
        bit          err_now, access, exp_err, timed_out;
        logic [31:0] exp_data, exp_strb, exp_wdata, v;

        off  = int'(addr[1:0]);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err_now = (ld && st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (!ld && st && f3 >= 3);
`ifdef MISALIGN_TRAP_EN
        if ((ld || st) && (off % size) != 0) err_now = 1'b1;
`endif
        eff       = off - (off % size);
        access    = (ld || st) && !err_now;
        timed_out = access && ld && !(k >= 1 && k <= TO);
        exp_err   = err_now || timed_out;
        if (!(ld || st))      exp_c = 0;
        else if (err_now)     exp_c = 1;
        else if (st)          exp_c = 2;
        else if (!timed_out)  exp_c = 2 + k;
        else                  exp_c = 2 + TO;

        exp_data = 32'h0;
        if (access && ld && !timed_out) begin
            v = word >> (8 * eff);
            if (size == 1) begin
                v = v % 256;
                if (f3 < 4 && v >= 128) v = v - 256;
            end else if (size == 2) begin
                v = v % 65536;
                if (f3 < 4 && v >= 32768) v = v - 65536;
            end
            exp_data = v;
        end
        exp_strb  = ((32'd1 << size) - 1) << eff;
        exp_wdata = (size == 1) ? data[7:0] * 32'h01010101 :
                    (size == 2) ? data[15:0] * 32'h00010001 : data;

        @(negedge clk);
        checkOutput("ready", {31'd0, req_ready_o}, 32'd1);
        req_valid_i  = 1'b1;
        memren_i     = ld;
        memwren_i    = st;
        funct3_i     = f3;
        addr_i       = addr;
        store_data_i = data;
        rd_i         = rd;

        resp_c = 0;
        stray  = 0;
        leak   = 0;
        for (int c = 1; c <= 16 && resp_c == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid_i  = 1'b0;
                memren_i     = 1'b0;
                memwren_i    = 1'b0;
                addr_i       = $urandom;
                store_data_i = $urandom;
            end
            dmem_rvalid_i = (k > 0 && c == 1 + k);
            dmem_rdata_i  = dmem_rvalid_i ? word : $urandom;
            #1;
            if (c == 1 && access) begin
                checkOutput("dmem_addr", dmem_addr_o, addr - off);
                checkOutput("read_en", {31'd0, dmem_read_en_o}, {31'd0, ld});
                checkOutput("write_en", {31'd0, dmem_write_en_o}, {31'd0, st});
                checkOutput("busy", {31'd0, busy_o}, 32'd1);
                if (st) begin
                    checkOutput("wstrb", {28'd0, dmem_wstrb_o}, exp_strb);
                    checkOutput("wdata", dmem_wdata_o, exp_wdata);
                end
            end else if (dmem_read_en_o || dmem_write_en_o) begin
                stray++;
            end
            if (resp_valid_o) begin
                resp_c = c;
                checkOutput("resp_data", resp_data_o, exp_data);
                checkOutput("resp_err", {31'd0, err_o}, {31'd0, exp_err});
                checkOutput("resp_wb", {31'd0, resp_wb_o}, {31'd0, ld && !exp_err});
                checkOutput("resp_rd", {27'd0, resp_rd_o}, {27'd0, rd});
            end else if (resp_data_o != 0 || err_o || resp_wb_o || resp_rd_o != 0) begin
                leak++;
            end
        end
        dmem_rvalid_i = 1'b0;
        checkOutput("resp_cycle", resp_c, exp_c);
        checkOutput("stray_en", stray, 0);
        checkOutput("resp_leak", leak, 0);
        if (resp_c != 0) begin
            @(negedge clk);
            #1;
            checkOutput("busy_after", {31'd0, busy_o}, 32'd0);
            checkOutput("resp_pulse", {31'd0, resp_valid_o}, 32'd0);
        end
    endtask

    // Reset asserted while a load sits in WAIT must abandon it silently
    task automatic resetDuringWait();
        int resp_seen;
        @(negedge clk);
        req_valid_i = 1'b1;
        memren_i    = 1'b1;
        funct3_i    = 3'b010;
        addr_i      = 32'h01000010;
        rd_i        = 5'd9;
        @(negedge clk);
        req_valid_i = 1'b0;
        memren_i    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_resp", {31'd0, resp_valid_o}, 32'd0);
        checkOutput("rst_ready", {31'd0, req_ready_o}, 32'd0);
        rst = 1'b0;
        resp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (resp_valid_o) resp_seen++;
        end
        checkOutput("rst_no_resp", resp_seen, 0);
        checkOutput("rst_ready_after", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        int          r, k;
        bit          ld, st;
        logic [2:0]  f3;

        rst           = 1'b1;
        req_valid_i   = 1'b0;
        memren_i      = 1'b0;
        memwren_i     = 1'b0;
        funct3_i      = 3'b000;
        addr_i        = 32'h0;
        store_data_i  = 32'h0;
        rd_i          = 5'd0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ready", {31'd0, req_ready_o}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_resp", {31'd0, resp_valid_o}, 32'd0);
        checkOutput("reset_en", {30'd0, dmem_read_en_o, dmem_write_en_o}, 32'd0);
        rst = 1'b0;

        applyStimulus(0, 1, 3'b010, 32'h01000004, 32'hDEADBEEF, 5'd3, 32'h0, 0);
        applyStimulus(0, 1, 3'b000, 32'h01000007, 32'h000000A5, 5'd4, 32'h0, 0);
        applyStimulus(1, 0, 3'b000, 32'h01000006, 32'h0, 5'd7, 32'h80FF1234, 3);
        applyStimulus(1, 0, 3'b101, 32'h01000002, 32'h0, 5'd8, 32'h80FF1234, 2);
        applyStimulus(1, 0, 3'b010, 32'h01000008, 32'h0, 5'd10, 32'h12345678, 0);
        applyStimulus(1, 0, 3'b010, 32'h01000008, 32'h0, 5'd11, 32'hCAFEF00D, TO);
        applyStimulus(1, 0, 3'b010, 32'h01000002, 32'h0, 5'd12, 32'h89ABCDEF, 1);
        applyStimulus(0, 1, 3'b001, 32'h01000003, 32'h0000BEEF, 5'd13, 32'h0, 0);
        applyStimulus(0, 0, 3'b010, 32'h01000000, 32'h0, 5'd14, 32'h0, 1);
        applyStimulus(1, 1, 3'b010, 32'h01000000, 32'h0, 5'd15, 32'h0, 1);
        applyStimulus(1, 0, 3'b011, 32'h01000000, 32'h0, 5'd16, 32'h0, 1);
        applyStimulus(0, 1, 3'b100, 32'h01000000, 32'h0, 5'd17, 32'h0, 1);

        resetDuringWait();

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 19);
            ld = (r == 1) || (r >= 2 && r < 11);
            st = (r == 1) || (r >= 11);
            f3 = 3'($urandom_range(0, 7));
            k  = $urandom_range(0, TO + 2);
            applyStimulus(ld, st, f3, $urandom, $urandom, 5'($urandom), $urandom, k);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
